// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, symbol width and receiver FSM states.
// The token constants are shared with the encoder, so both ends agree on the code words.
package tmds_pkg;
   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] TOK_00 = 10'b0010101011;
   localparam logic [SYM_W-1:0] TOK_01 = 10'b1101010100;
   localparam logic [SYM_W-1:0] TOK_10 = 10'b0010101010;
   localparam logic [SYM_W-1:0] TOK_11 = 10'b1101010101;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;
endpackage

// File: rtl/tmds_symbol_decoder.sv
// Combinational TMDS symbol decoder: recognises control tokens, else undoes the
// DC-balance inversion and the XOR/XNOR transition chain to recover the data byte.
module tmds_symbol_decoder
   import tmds_pkg::*;
(
   input  logic [SYM_W-1:0] i_sym,
   output logic             o_is_token,
   output logic             o_c1,
   output logic             o_c0,
   output logic [7:0]       o_d
);

   logic [7:0] w_t;
   logic [6:0] w_x;

   assign w_t = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
   assign w_x = w_t[7:1] ^ w_t[6:0];

   always_comb begin
      o_is_token = 1'b1;
      o_c1       = 1'b0;
      o_c0       = 1'b0;
      o_d        = 8'd0;
      case (i_sym)
         TOK_00: begin o_c1 = 1'b0; o_c0 = 1'b0; end
         TOK_01: begin o_c1 = 1'b0; o_c0 = 1'b1; end
         TOK_10: begin o_c1 = 1'b1; o_c0 = 1'b0; end
         TOK_11: begin o_c1 = 1'b1; o_c0 = 1'b1; end
         default: begin
            o_is_token = 1'b0;
            o_d        = {(i_sym[8] ? w_x : ~w_x), w_t[0]};
         end
      endcase
   end

endmodule

// File: rtl/tmds_channel_receiver.sv
// One TMDS receive channel: aligns the free-running deserializer word to the symbol
// boundary using control-token runs, then decodes pixel data / control pairs.
module tmds_channel_receiver
   import tmds_pkg::*;
#(
   parameter int LOCK_TOKENS   = 8,
   parameter int SEARCH_WINDOW = 1024
) (
   input  logic             pix_clk,
   input  logic             rst,
   input  logic [SYM_W-1:0] raw_in,
   output logic [7:0]       d_out,
   output logic             de_out,
   output logic             c0_out,
   output logic             c1_out,
   output logic             locked,
   output logic [3:0]       bit_offset,
   output logic [7:0]       lock_loss_cnt
);

   localparam int RUN_W = $clog2(LOCK_TOKENS + 1);
   localparam int WIN_W = $clog2(SEARCH_WINDOW);

   logic [SYM_W-1:0] r_prev, r_cur;
   logic [3:0]       r_offset;
   logic [RUN_W-1:0] r_run;
   logic [WIN_W-1:0] r_win;
   logic             r_seen;
   logic [7:0]       r_loss;
   state_t           r_state, w_state_next;

   logic [19:0]      w_win;
   logic [4:0]       w_msb;
   logic [SYM_W-1:0] w_sym;
   logic             w_tok, w_c1, w_c0;
   logic [7:0]       w_d;
   logic             w_hit, w_wend, w_adv, w_loss, w_seen_set, w_seen_clr;
   logic [3:0]       w_off_next;

   // Offset k selects the 10 bits starting k bits into the older word.
   assign w_win = {r_prev, r_cur};
   assign w_msb = 5'd19 - {1'b0, r_offset};
   assign w_sym = w_win[w_msb -: SYM_W];

   tmds_symbol_decoder u_dec (
      .i_sym      (w_sym),
      .o_is_token (w_tok),
      .o_c1       (w_c1),
      .o_c0       (w_c0),
      .o_d        (w_d)
   );

   assign w_hit      = w_tok && (r_run == RUN_W'(LOCK_TOKENS - 1));
   assign w_wend     = (r_win == WIN_W'(SEARCH_WINDOW - 1));
   assign w_off_next = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

   always_ff @(posedge pix_clk) begin
      if (rst) r_state <= SEARCH;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         SEARCH:  if (w_hit) w_state_next = LOCKED;
         LOCKED:  if (w_wend && !(r_seen || w_hit)) w_state_next = SEARCH;
         default: w_state_next = SEARCH;
      endcase
   end

   // A run hit coinciding with a window end keeps (or takes) the lock.
   always_comb begin
      w_adv      = 1'b0;
      w_loss     = 1'b0;
      w_seen_set = 1'b0;
      w_seen_clr = 1'b0;
      case (r_state)
         SEARCH: begin
            if (w_hit)       w_seen_clr = 1'b1;
            else if (w_wend) w_adv      = 1'b1;
         end
         LOCKED: begin
            if (w_wend) begin
               if (r_seen || w_hit) begin
                  w_seen_clr = 1'b1;
               end else begin
                  w_adv  = 1'b1;
                  w_loss = 1'b1;
               end
            end else if (w_hit) begin
               w_seen_set = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         r_prev   <= '0;
         r_cur    <= '0;
         r_offset <= 4'd0;
         r_run    <= '0;
         r_win    <= '0;
         r_seen   <= 1'b0;
         r_loss   <= 8'd0;
      end else begin
         r_prev <= r_cur;
         r_cur  <= raw_in;
         if (w_adv) begin
            r_offset <= w_off_next;
            r_run    <= '0;
         end else if (w_tok) begin
            if (r_run != RUN_W'(LOCK_TOKENS)) r_run <= r_run + 1'b1;
         end else begin
            r_run <= '0;
         end
         if (w_wend || (w_state_next != r_state)) r_win <= '0;
         else                                     r_win <= r_win + 1'b1;
         if (w_seen_clr)      r_seen <= 1'b0;
         else if (w_seen_set) r_seen <= 1'b1;
         if (w_loss && (r_loss != 8'hFF)) r_loss <= r_loss + 8'd1;
      end
   end

   // Gating follows the state being entered, so the run-hit token is the first valid output.
   always_ff @(posedge pix_clk) begin
      if (rst || (w_state_next != LOCKED)) begin
         d_out  <= 8'd0;
         de_out <= 1'b0;
         c1_out <= 1'b0;
         c0_out <= 1'b0;
      end else begin
         d_out  <= w_d;
         de_out <= ~w_tok;
         c1_out <= w_c1;
         c0_out <= w_c0;
      end
   end

   assign locked        = (r_state == LOCKED);
   assign bit_offset    = r_offset;
   assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_tmds_channel_receiver.sv
// Self-checking bench for tmds_channel_receiver: a full-size instance and a short-window
// instance, both compared each cycle against a behavioural model driven by an encoder-built table.
module tb_tmds_channel_receiver;
   import tmds_pkg::*;

   localparam int SW_A = 1024;
   localparam int SW_B = 32;
   localparam int LT   = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, rst_b = 1'b1;
   logic [9:0] raw_a = '0, raw_b = '0;
   logic [7:0] a_d, b_d, a_loss, b_loss;
   logic       a_de, a_c0, a_c1, a_lk, b_de, b_c0, b_c1, b_lk;
   logic [3:0] a_off, b_off;

   tmds_channel_receiver #(.LOCK_TOKENS(LT), .SEARCH_WINDOW(SW_A)) dut_a (
      .pix_clk(clk), .rst(rst_a), .raw_in(raw_a), .d_out(a_d), .de_out(a_de),
      .c0_out(a_c0), .c1_out(a_c1), .locked(a_lk), .bit_offset(a_off),
      .lock_loss_cnt(a_loss));

   tmds_channel_receiver #(.LOCK_TOKENS(LT), .SEARCH_WINDOW(SW_B)) dut_b (
      .pix_clk(clk), .rst(rst_b), .raw_in(raw_b), .d_out(b_d), .de_out(b_de),
      .c0_out(b_c0), .c1_out(b_c1), .locked(b_lk), .bit_offset(b_off),
      .lock_loss_cnt(b_loss));

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 0;
   int dec_tab[1024];

   typedef struct {
      logic [9:0] prev, cur;
      int off, run, win, st, seen, loss, d, de, c1, c0, dknown;
   } mstate_t;
   mstate_t ma, mb;

   logic [9:0] last_a = '0, last_b = '0;
   int rot_a = 0, rot_b = 0;

   // Transmit-side TMDS data encoding (transition minimisation, then optional inversion).
   function automatic logic [9:0] enc(input int dv, input bit inv);
      logic [7:0] dd;
      logic [8:0] q;
      bit xn;
      dd = dv[7:0];
      xn = ($countones(dd) > 4) || ($countones(dd) == 4 && dd[0] == 1'b0);
      q[0] = dd[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ dd[i]) : (q[i-1] ^ dd[i]);
      q[8] = ~xn;
      return inv ? {1'b1, q[8], ~q[7:0]} : {1'b0, q[8], q[7:0]};
   endfunction

   function automatic logic [9:0] rnd_sym(input int dv);
      return enc(dv, bit'($urandom_range(0, 1)));
   endfunction

   function automatic void mstep(inout mstate_t m, input logic [9:0] raw, input logic r,
                                 input int sw);
      logic [19:0] w;
      logic [9:0]  sym;
      int tk, runn, nl;
      bit hit, wend;
      if (r) begin
         m = '{default: 0};
      end else begin
         w   = {m.prev, m.cur};
         sym = 10'(w >> (10 - m.off));
         tk  = -1;
         if (sym == TOK_00) tk = 0;
         if (sym == TOK_01) tk = 1;
         if (sym == TOK_10) tk = 2;
         if (sym == TOK_11) tk = 3;
         runn = (tk >= 0) ? ((m.run + 1 > LT) ? LT : m.run + 1) : 0;
         hit  = (tk >= 0) && (m.run + 1 == LT);
         wend = (m.win == sw - 1);
         nl   = m.st;
         if (m.st == 0) begin
            if (hit) begin
               nl = 1; m.seen = 0; m.win = 0; m.run = runn;
            end else if (wend) begin
               m.off = (m.off + 1) % 10; m.run = 0; m.win = 0;
            end else begin
               m.run = runn; m.win++;
            end
         end else begin
            m.run = runn;
            if (wend) begin
               m.win = 0;
               if (m.seen != 0 || hit) m.seen = 0;
               else begin
                  nl = 0; m.off = (m.off + 1) % 10; m.run = 0;
                  if (m.loss < 255) m.loss++;
               end
            end else begin
               if (hit) m.seen = 1;
               m.win++;
            end
         end
         m.st = nl;
         m.de = 0; m.c1 = 0; m.c0 = 0; m.d = 0; m.dknown = 1;
         if (nl != 0) begin
            if (tk >= 0) begin
               m.c1 = tk / 2; m.c0 = tk % 2;
            end else begin
               m.de = 1;
               if (dec_tab[sym] < 0) m.dknown = 0;
               else m.d = dec_tab[sym];
            end
         end
         m.prev = m.cur;
         m.cur  = raw;
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp(input string nm, input logic lk, de, c1, c0, input logic [7:0] d,
                      input logic [3:0] off, input logic [7:0] loss, input mstate_t m);
      logic [15:0] act, exp;
      bit bad;
      act = {lk, de, c1, c0, off, loss};
      exp = {m.st[0], m.de[0], m.c1[0], m.c0[0], m.off[3:0], m.loss[7:0]};
      bad = (act !== exp) || (m.dknown != 0 && d !== m.d[7:0]);
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL %s @%0t: got lk=%b de=%b c=%b%b d=%0d off=%0d loss=%0d, expected lk=%0d de=%0d c=%0d%0d d=%0d off=%0d loss=%0d",
                  nm, $time, lk, de, c1, c0, d, off, loss,
                  m.st, m.de, m.c1, m.c0, m.d, m.off, m.loss);
      end
   endtask

   always @(posedge clk) begin
      mstep(ma, raw_a, rst_a, SW_A);
      mstep(mb, raw_b, rst_b, SW_B);
   end

   always @(negedge clk) begin
      if (chk_on) begin
         cmp("model_a", a_lk, a_de, a_c1, a_c0, a_d, a_off, a_loss, ma);
         cmp("model_b", b_lk, b_de, b_c1, b_c0, b_d, b_off, b_loss, mb);
      end
   end

   task automatic send_a(input logic [9:0] s);
      raw_a  = 10'({last_a, s} >> rot_a);
      last_a = s;
      @(posedge clk); #1;
   endtask

   task automatic send_b(input logic [9:0] s);
      raw_b  = 10'({last_b, s} >> rot_b);
      last_b = s;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] toks[4];
      int first_lock, q_off[$], prev_off, off_at, loss_at, de_at, d_at, tries;
      bit drop_seen, ever_locked, saw9, wrapped;
      toks = '{TOK_00, TOK_01, TOK_10, TOK_11};

      for (int i = 0; i < 1024; i++) dec_tab[i] = -1;
      for (int dv = 0; dv < 256; dv++) begin
         dec_tab[enc(dv, 1'b0)] = dv;
         dec_tab[enc(dv, 1'b1)] = dv;
      end
      chk("enc145_pos", enc(145, 1'b0), 10'h18F);
      chk("enc145_neg", enc(145, 1'b1), 10'h370);
      chk("enc0_pos", enc(0, 1'b0), 10'h100);
      chk("dec_tab_145", dec_tab[10'h370], 145);

      repeat (2) @(posedge clk);
      #1;
      chk_on = 1;
      chk("rst_locked", a_lk, 0);
      chk("rst_off", a_off, 0);
      chk("rst_loss", a_loss, 0);

      // Aligned stream: 8 tokens, then D=145 in both polarities.
      rst_a = 1'b0;
      repeat (8) send_a(TOK_00);
      send_a(enc(145, 1'b0));
      send_a(enc(145, 1'b1));
      chk("align_locked", a_lk, 1);
      chk("align_tok_de", {a_de, a_c1, a_c0}, 3'b000);
      send_a(enc(145, 1'b0));
      chk("align_d145_pos", {a_de, a_d}, {1'b1, 8'd145});
      send_a(enc(145, 1'b0));
      chk("align_d145_neg", {a_de, a_d}, {1'b1, 8'd145});
      repeat (20) send_a(rnd_sym($urandom_range(0, 255)));

      // Mid-stream reset while locked.
      rst_a = 1'b1;
      repeat (2) send_a(rnd_sym(145));
      chk("mrst_locked", a_lk, 0);
      chk("mrst_outs", {a_de, a_d}, 9'd0);
      chk("mrst_off", a_off, 0);
      chk("mrst_loss", a_loss, 0);
      rst_a = 1'b0;

      // Stream rotated by 3 bits, 800-cycle lines with 160 blanking tokens.
      rot_a = 3; last_a = '0; first_lock = -1; prev_off = 0;
      for (int c = 0; c < 7 * 800; c++) begin
         if (c % 800 < 160) send_a(TOK_00);
         else send_a(rnd_sym(((c % 2) != 0) ? 100 : 200));
         if (first_lock < 0 && a_lk) first_lock = c + 1;
         if (a_off != prev_off[3:0]) begin
            q_off.push_back(int'(a_off));
            prev_off = int'(a_off);
         end
         if (c == 6 * 800 + 500) chk("rot_data", (a_d == 200 || a_d == 100) && a_de, 1);
      end
      chk("rot_lock_found", first_lock > 0, 1);
      chk("rot_lock_time", first_lock <= 4 * SW_A + 800, 1);
      chk("rot_offset", a_off, 3);
      chk("rot_steps_n", q_off.size(), 3);
      if (q_off.size() == 3) begin
         chk("rot_step1", q_off[0], 1);
         chk("rot_step2", q_off[1], 2);
         chk("rot_step3", q_off[2], 3);
      end

      // Control pairs while locked.
      for (int p = 0; p < 4; p++) begin
         repeat (12) send_a(toks[p]);
         chk($sformatf("pair%0d_c", p), {a_c1, a_c0}, p);
         chk($sformatf("pair%0d_de_d", p), {a_de, a_d}, 9'd0);
         repeat (8) send_a(toks[p]);
         repeat (40) send_a(rnd_sym($urandom_range(0, 255)));
      end
      chk("pairs_locked", a_lk, 1);

      // Loss of lock on a data-only stream.
      drop_seen = 0; off_at = 0; loss_at = 0; de_at = 0; d_at = 0;
      for (int c = 0; c < 2100; c++) begin
         send_a(rnd_sym($urandom_range(0, 255)));
         if (!drop_seen && !a_lk) begin
            drop_seen = 1; off_at = int'(a_off); loss_at = int'(a_loss);
            de_at = int'(a_de); d_at = int'(a_d);
         end
      end
      chk("loss_dropped", drop_seen, 1);
      chk("loss_off", off_at, 4);
      chk("loss_cnt_at", loss_at, 1);
      chk("loss_outs", {de_at[0], d_at[7:0]}, 9'd0);
      chk("loss_cnt_end", a_loss, 1);

      // Seven-token runs never lock; offset sweeps and wraps.
      rst_a = 1'b1;
      rot_a = 0; last_a = '0;
      repeat (2) send_a(TOK_00);
      rst_a = 1'b0;
      ever_locked = 0; saw9 = 0; wrapped = 0;
      for (int c = 0; c < 11 * SW_A + 100; c++) begin
         if (c % 10 < 7) send_a(TOK_00);
         else send_a(rnd_sym($urandom_range(0, 255)));
         if (a_lk) ever_locked = 1;
         if (a_off == 4'd9) saw9 = 1;
         if (saw9 && a_off == 4'd0) wrapped = 1;
      end
      chk("seven_never_locked", ever_locked, 0);
      chk("seven_wrapped", wrapped, 1);

      // Saturation of lock_loss_cnt on the short-window instance.
      rst_a = 1'b1;
      send_b(TOK_00);
      send_b(TOK_00);
      rst_b = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         rot_b = mb.off;
         repeat (12) send_b(TOK_00);
         chk("sat_relock", b_lk, 1);
         tries = 0;
         while (b_lk && tries < 4 * SW_B) begin
            send_b(rnd_sym($urandom_range(0, 255)));
            tries++;
         end
         chk("sat_drop", b_lk, 0);
         if (i == 1)   chk("sat_cnt1", b_loss, 1);
         if (i == 100) chk("sat_cnt100", b_loss, 100);
      end
      chk("sat_cnt255", b_loss, 255);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
